// File: rtl/serial_shift_tx.sv
// serial_shift_tx
//   Serialises one SHIFT_WIDTH-bit frame, MSB first, into an external
//   shift/storage register pair (e.g. a chain of 595-style segment drivers).
//   Each bit is presented with o_serial_clk low for HALF system cycles. The
//   clock is then held high for HALF cycles. After bit 0, o_serial_latch is
//   pulsed high for HALF cycles and then held low for HALF cycles before the
//   block returns to idle.
//
// Ports
//   i_clk          system clock, all logic on its rising edge
//   i_reset_n      synchronous active-low reset
//   i_data         parallel frame, captured on the accepting edge
//   i_valid        transmit request, honoured only while o_ready=1
//   o_ready        high only in IDLE
//   o_serial_data  serial data, valid around the o_serial_clk rising edge
//   o_serial_clk   shift clock to the receiver
//   o_serial_latch storage latch strobe to the receiver
//
// State table
//   IDLE     | waiting for a frame, all serial lines low
//   SHIFT_LO | current bit driven, shift clock low
//   SHIFT_HI | current bit held, shift clock high (receiver samples)
//   LATCH_HI | all bits shifted, latch strobe high
//   LATCH_LO | latch strobe low, final settle before idle

module serial_shift_tx #(
  parameter int SYS_CLK_HZ   = 50_000_000,
  parameter int SHIFT_CLK_HZ = 1_000_000,
  parameter int SHIFT_WIDTH  = 48
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [SHIFT_WIDTH-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_serial_data,
  output logic                   o_serial_clk,
  output logic                   o_serial_latch
);

  localparam int HALF  = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_W = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(SHIFT_WIDTH - 1);

  if (HALF < 1) begin : g_bad_half
    $error("serial_shift_tx: SYS_CLK_HZ must be at least 2*SHIFT_CLK_HZ");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH_HI = 3'd3,
    LATCH_LO = 3'd4
  } state_t;

  state_t                 r_state;
  logic [DIV_W-1:0]       r_div;
  logic [BIT_W-1:0]       r_bit;
  logic [SHIFT_WIDTH-1:0] r_frame;

  // Frame advanced by one bit; its MSB is the next bit to present.
  logic [SHIFT_WIDTH-1:0] w_frame_next;
  logic                   w_div_done;

  assign w_frame_next = r_frame << 1;
  assign w_div_done   = (r_div == '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= IDLE;
      r_div          <= '0;
      r_bit          <= '0;
      r_frame        <= '0;
      o_ready        <= 1'b1;
      o_serial_data  <= 1'b0;
      o_serial_clk   <= 1'b0;
      o_serial_latch <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_serial_data  <= 1'b0;
          o_serial_clk   <= 1'b0;
          o_serial_latch <= 1'b0;
          if (i_valid) begin
            r_frame       <= i_data;
            o_serial_data <= i_data[SHIFT_WIDTH-1];
            r_div         <= DIV_MAX;
            r_bit         <= BIT_MAX;
            o_ready       <= 1'b0;
            r_state       <= SHIFT_LO;
          end
        end

        SHIFT_LO: begin
          if (w_div_done) begin
            r_div        <= DIV_MAX;
            o_serial_clk <= 1'b1;
            r_state      <= SHIFT_HI;
          end else begin
            r_div <= r_div - DIV_W'(1);
          end
        end

        SHIFT_HI: begin
          if (w_div_done) begin
            r_div        <= DIV_MAX;
            o_serial_clk <= 1'b0;
            if (r_bit == '0) begin
              o_serial_data  <= 1'b0;
              o_serial_latch <= 1'b1;
              r_state        <= LATCH_HI;
            end else begin
              // Next bit goes out on the same edge the clock falls.
              r_bit         <= r_bit - BIT_W'(1);
              r_frame       <= w_frame_next;
              o_serial_data <= w_frame_next[SHIFT_WIDTH-1];
              r_state       <= SHIFT_LO;
            end
          end else begin
            r_div <= r_div - DIV_W'(1);
          end
        end

        LATCH_HI: begin
          if (w_div_done) begin
            r_div          <= DIV_MAX;
            o_serial_latch <= 1'b0;
            r_state        <= LATCH_LO;
          end else begin
            r_div <= r_div - DIV_W'(1);
          end
        end

        LATCH_LO: begin
          if (w_div_done) begin
            r_frame <= '0;
            o_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_div <= r_div - DIV_W'(1);
          end
        end

        default: begin
          r_state        <= IDLE;
          r_div          <= '0;
          r_bit          <= '0;
          o_ready        <= 1'b1;
          o_serial_data  <= 1'b0;
          o_serial_clk   <= 1'b0;
          o_serial_latch <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_tx.sv
module tb_serial_shift_tx;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_reset_n;
  logic [W-1:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic         o_serial_data;
  logic         o_serial_clk;
  logic         o_serial_latch;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];

  // receiver model state
  logic [W-1:0] rx_sr      = '0;
  int           clk_rises  = 0;
  int           last_rise  = 0;
  int           latch_rise = 0;
  int           latch_cnt  = 0;
  logic         prev_clk   = 1'b0;
  logic         prev_latch = 1'b0;

  serial_shift_tx #(
    .SYS_CLK_HZ  (8),
    .SHIFT_CLK_HZ(2),
    .SHIFT_WIDTH (W)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_serial_data (o_serial_data),
    .o_serial_clk  (o_serial_clk),
    .o_serial_latch(o_serial_latch)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: receiver model plus scoreboard, sampled 1 time unit after each edge.
  always begin
    @(posedge i_clk);
    #1;
    if (!i_reset_n) begin
      clk_rises = 0;
    end else begin
      if (o_serial_clk && !prev_clk) begin
        if (clk_rises > 0) chk("clk_rise_spacing", cyc - last_rise, 4);
        rx_sr     = {rx_sr[W-2:0], o_serial_data};
        clk_rises = clk_rises + 1;
        last_rise = cyc;
      end
      if (o_serial_latch && !prev_latch) begin
        latch_cnt  = latch_cnt + 1;
        latch_rise = cyc;
        chk("clk_rises_per_frame", clk_rises, W);
        clk_rises = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_latch", 1, 0);
        end else begin
          chk("rx_frame", int'(rx_sr), int'(exp_q.pop_front()));
        end
      end
      if (!o_serial_latch && prev_latch) chk("latch_width", cyc - latch_rise, 2);
    end
    prev_clk   = o_serial_clk;
    prev_latch = o_serial_latch;
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, int'(o_ready), 1);
    chk({tag, "_sclk"},  int'(o_serial_clk), 0);
    chk({tag, "_latch"}, int'(o_serial_latch), 0);
    chk({tag, "_sdata"}, int'(o_serial_data), 0);
  endtask

  // Issue one frame; i_data is scrambled right after acceptance.
  task automatic send(input logic [W-1:0] d, output int t_acc);
    @(negedge i_clk);
    chk("ready_before_send", int'(o_ready), 1);
    i_data  = d;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    t_acc = cyc;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_data  = ~d;
    chk("ready_low_after_accept", int'(o_ready), 0);
  endtask

  task automatic wait_ready(output int c);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge i_clk);
      if (o_ready) got = 1'b1;
    end
    chk("ready_timeout", int'(got), 1);
    c = cyc;
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 200 && cyc < target; i++) @(negedge i_clk);
  endtask

  initial begin
    int t, t2, c;
    // reset with a request pending: request must be ignored
    i_reset_n = 1'b0;
    i_valid   = 1'b1;
    i_data    = 8'h55;
    repeat (4) @(negedge i_clk);
    chk_idle("reset");
    i_reset_n = 1'b1;
    i_valid   = 1'b0;
    @(negedge i_clk);
    chk("no_accept_in_reset", int'(o_ready), 1);

    // single frame
    exp_q.push_back(8'hA5);
    send(8'hA5, t);
    wait_ready(c);
    chk("ready_return_edge", c + 1 - t, 37);
    chk("latch_count_a5", latch_cnt, 1);

    // back-to-back with i_valid held high
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    @(negedge i_clk);
    i_data  = 8'h3C;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    t = cyc;
    @(negedge i_clk);
    i_data = 8'hC3;
    wait_ready(c);
    @(posedge i_clk);
    #1;
    t2 = cyc;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_data  = 8'h00;
    chk("b2b_second_accepted", int'(o_ready), 0);
    chk("b2b_accept_gap", t2 - t, 37);
    wait_ready(c);
    chk("latch_count_b2b", latch_cnt, 3);

    // request while busy is dropped
    exp_q.push_back(8'h00);
    send(8'h00, t);
    wait_until(t + 9);
    i_data  = 8'hFF;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    wait_ready(c);
    repeat (45) @(negedge i_clk);
    chk("busy_ignore_latches", latch_cnt, 4);
    chk("busy_ignore_queue", exp_q.size(), 0);
    chk("busy_ignore_ready", int'(o_ready), 1);

    // reset in the middle of a frame
    send(8'h81, t);
    wait_until(t + 14);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    chk_idle("midreset");
    repeat (40) @(negedge i_clk);
    chk("midreset_no_latch", latch_cnt, 4);

    exp_q.push_back(8'h7E);
    send(8'h7E, t);
    wait_ready(c);
    chk("ready_return_7e", c + 1 - t, 37);
    repeat (4) @(negedge i_clk);
    chk("final_latches", latch_cnt, 5);
    chk("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_shift_tx.md
SERIAL_SHIFT_TX -- requirements
Module: serial_shift_tx

Interface
REQ-001 SHALL have parameter SYS_CLK_HZ, 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SHIFT_CLK_HZ, 1_000_000, serial clock frequency in Hz.
REQ-003 SHALL have parameter SHIFT_WIDTH, 48, bits per frame (6 digits x 8 segments).
REQ-004 SHALL have port i_clk  input  1  system clock; the block has one clock and all logic is on its rising edge.
REQ-005 SHALL have port i_reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port i_data  input  SHIFT_WIDTH  parallel frame to transmit.
REQ-007 SHALL have port i_valid  input  1  request to transmit i_data.
REQ-008 SHALL have port o_ready  output  1  high when idle and able to accept a frame.
REQ-009 SHALL have port o_serial_data  output  1  serial data to external shift register.
REQ-010 SHALL have port o_serial_clk  output  1  shift clock; receiver samples o_serial_data on its rising edge.
REQ-011 SHALL have port o_serial_latch  output  1  storage latch; receiver transfers its shift register to outputs on its rising edge.

Function
REQ-012 SHALL define HALF = SYS_CLK_HZ / (2*SHIFT_CLK_HZ), integer division; HALF SHALL be >= 1 (elaboration error otherwise).
REQ-013 SHALL implement states IDLE, SHIFT_LO, SHIFT_HI, LATCH_HI, LATCH_LO, each held exactly HALF system cycles except IDLE.
REQ-014 SHALL accept a frame only on a rising edge where i_valid=1 and o_ready=1 (edge T); i_data is registered at T and later i_data changes SHALL NOT affect the frame.
REQ-015 SHALL drive o_ready=1 only in IDLE; o_ready SHALL be 0 from T+1 onward until the frame completes.
REQ-016 SHALL, at T+1, enter SHIFT_LO with o_serial_clk=0 and o_serial_data=i_data[SHIFT_WIDTH-1] (MSB first).
REQ-017 SHALL, after HALF cycles in SHIFT_LO, enter SHIFT_HI with o_serial_clk=1 and o_serial_data unchanged.
REQ-018 SHALL, after HALF cycles in SHIFT_HI, if bits remain, return to SHIFT_LO with o_serial_clk=0 and the next lower bit on o_serial_data in the same cycle.
REQ-019 SHALL, after the SHIFT_HI of bit 0, enter LATCH_HI with o_serial_clk=0, o_serial_latch=1, o_serial_data=0.
REQ-020 SHALL, after HALF cycles in LATCH_HI, enter LATCH_LO with o_serial_latch=0; after HALF cycles, enter IDLE.
REQ-021 SHALL produce exactly SHIFT_WIDTH rising edges of o_serial_clk and exactly one rising edge of o_serial_latch per frame.
REQ-022 SHALL return o_ready=1 at T+1+(2*SHIFT_WIDTH+2)*HALF.
REQ-023 SHALL ignore i_valid while o_ready=0 (no queuing); a frame presented on the cycle o_ready returns high SHALL be accepted that cycle.
REQ-024 SHALL keep bit counter and divider counter sized ceil(log2) of SHIFT_WIDTH and HALF respectively, with no wrap-around mid-frame.
REQ-025 SHALL hold in IDLE: o_serial_clk=0, o_serial_latch=0, o_serial_data=0.
REQ-026 SHALL register all outputs (no combinational paths from inputs to outputs).

Reset
REQ-027 SHALL, on any rising edge with i_reset_n=0, enter IDLE, clear counters and frame register, and drive o_ready=1, o_serial_clk=0, o_serial_latch=0, o_serial_data=0 from the next cycle.
REQ-028 SHALL abort an in-progress frame on reset without emitting a latch pulse.
REQ-029 SHALL ignore i_valid while i_reset_n=0.

Verification (bench: SYS_CLK_HZ=8, SHIFT_CLK_HZ=2 -> HALF=2, SHIFT_WIDTH=8, receiver model shifting LSB-in on o_serial_clk rise and capturing on o_serial_latch rise)
REQ-030 SHALL verify reset: hold i_reset_n=0 4 cycles -> o_ready=1, o_serial_clk=0, o_serial_latch=0, o_serial_data=0.
REQ-031 SHALL verify single frame: i_data=8'hA5, i_valid pulse at T -> receiver captures 8'hA5, 8 serial clock rises each 4 cycles apart, one latch pulse 2 cycles wide, o_ready=1 at T+37.
REQ-032 SHALL verify back-to-back: i_valid held high with 8'h3C then 8'hC3 -> second frame accepted at T+37, receiver shows 8'h3C then 8'hC3.
REQ-033 SHALL verify busy-ignore: i_valid with 8'hFF at T+10 during frame 8'h00 -> only 8'h00 latched, no second frame.
REQ-034 SHALL verify mid-frame reset: reset asserted at T+15 of frame 8'h81 -> no latch rise, outputs idle next cycle, new frame 8'h7E afterwards latches 8'h7E.
REQ-035 SHALL verify data stability: i_data changed at T+1 -> transmitted frame equals value sampled at T.
